// File: rtl/in_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : in_port_pkg
// Description : Shared types and constants for the INport capture front-end.
//               Holds the channel FSM state type, the channel read
//               addresses (these must match INport's address decode), the
//               channel count and a helper that maps a channel index to its
//               read address.
// Revision    : 1.0 - initial release
// ============================================================================
package in_port_pkg;

    localparam int NUM_CH = 4;

    localparam logic [7:0] CH0_ADDR = 8'h00;
    localparam logic [7:0] CH1_ADDR = 8'h01;
    localparam logic [7:0] CH2_ADDR = 8'h02;
    localparam logic [7:0] CH3_ADDR = 8'h03;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } chan_state_e;

    // Maps a channel index to the INport address that reads that channel.
    function automatic logic [7:0] ch_addr(input int idx);
        logic [7:0] addr;
        case (idx)
            0:       addr = CH0_ADDR;
            1:       addr = CH1_ADDR;
            2:       addr = CH2_ADDR;
            default: addr = CH3_ADDR;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_port_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : in_port_capture_if
// Description : Bundles the device-side handshake, the INport read bus and
//               the holding-register / status outputs of in_port_capture.
//   master : drives ExtStrobe, ExtData1..4, INportRead, Address
//            (devices plus CPU/INport side); observes the rest.
//   slave  : the capture block; drives ExtAck, InpExtWorld1..4,
//            DataReady, Overrun.
// Revision    : 1.0 - initial release
// ============================================================================
interface in_port_capture_if #(
    parameter int DATA_W = 8
);
    logic [in_port_pkg::NUM_CH-1:0] ExtStrobe;
    logic [DATA_W-1:0]              ExtData1;
    logic [DATA_W-1:0]              ExtData2;
    logic [DATA_W-1:0]              ExtData3;
    logic [DATA_W-1:0]              ExtData4;
    logic [in_port_pkg::NUM_CH-1:0] ExtAck;
    logic                           INportRead;
    logic [7:0]                     Address;
    logic [DATA_W-1:0]              InpExtWorld1;
    logic [DATA_W-1:0]              InpExtWorld2;
    logic [DATA_W-1:0]              InpExtWorld3;
    logic [DATA_W-1:0]              InpExtWorld4;
    logic [in_port_pkg::NUM_CH-1:0] DataReady;
    logic [in_port_pkg::NUM_CH-1:0] Overrun;

    modport master (
        output ExtStrobe, ExtData1, ExtData2, ExtData3, ExtData4,
        output INportRead, Address,
        input  ExtAck, InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4,
        input  DataReady, Overrun
    );

    modport slave (
        input  ExtStrobe, ExtData1, ExtData2, ExtData3, ExtData4,
        input  INportRead, Address,
        output ExtAck, InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4,
        output DataReady, Overrun
    );

endinterface
`default_nettype wire

// File: rtl/in_port_chan.sv
`default_nettype none
// ============================================================================
// Module      : in_port_chan
// Description : One capture channel: strobe synchronizer, IDLE/ACK
//               four-phase handshake FSM, data holding register, data-ready
//               flag and (optionally) a sticky overrun flag.
//   Ports : clk, rst (async active-high)
//           i_ext_strobe  async device strobe
//           i_ext_data    device data, stable while strobe is high
//           i_rd_en/i_rd_addr  INport read enable and address
//           o_ext_ack     acknowledge to the device
//           o_data        holding register
//           o_ready       unread byte held
//           o_overrun     byte overwritten before it was read
//   Option : INPORT_CAPTURE_OVERWRITE_EN - capture into a full channel
//            (setting overrun) instead of stalling the device.
// Revision    : 1.0 - initial release
// ============================================================================
module in_port_chan
    import in_port_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter int         SYNC_STAGES = 2,   // must be at least 2
    parameter logic [7:0] ADDR        = 8'h00
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_ext_strobe,
    input  wire logic [DATA_W-1:0] i_ext_data,
    input  wire logic              i_rd_en,
    input  wire logic [7:0]        i_rd_addr,
    output logic                   o_ext_ack,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_ready,
    output logic                   o_overrun
);

    chan_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q,  sync_d;
    logic                     ack_q,   ack_d;
    logic [DATA_W-1:0]        data_q,  data_d;
    logic                     ready_q, ready_d;
    logic                     w_strb_s;
    logic                     w_rd_hit;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
    logic                     ovr_q,   ovr_d;
`endif

    assign w_strb_s = sync_q[SYNC_STAGES-1];
    assign w_rd_hit = i_rd_en && (i_rd_addr == ADDR);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_ext_strobe};
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        ready_d = ready_q;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
        ovr_d   = ovr_q;
`endif

        // Read clear is applied first so that a capture on the same edge
        // (overwrite case) takes priority over it.
        if (w_rd_hit) begin
            ready_d = 1'b0;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
            ovr_d   = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                // Capture depends on ready_q (this cycle's flag), so a read
                // that frees a full channel lets the capture happen one
                // edge later.
                if (w_strb_s && !ready_q) begin
                    data_d  = i_ext_data;
                    ready_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
`ifdef INPORT_CAPTURE_OVERWRITE_EN
                else if (w_strb_s) begin
                    data_d  = i_ext_data;
                    ready_d = 1'b1;
                    ovr_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
`endif
            end
            ACK: begin
                if (!w_strb_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            ready_q <= ready_d;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign o_ext_ack = ack_q;
    assign o_data    = data_q;
    assign o_ready   = ready_q;
`ifdef INPORT_CAPTURE_OVERWRITE_EN
    assign o_overrun = ovr_q;
`else
    assign o_overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/in_port_capture.sv
`default_nettype none
// ============================================================================
// Module      : in_port_capture
// Description : Four-channel strobe/ack capture front-end for INport. Each
//               channel captures a device byte into a holding register that
//               drives INport's InpExtWorld1..4 inputs, flags DataReady, and
//               clears the flag when the CPU reads that channel's address.
//   Ports : clk, Reset (async active-high), bus (in_port_capture_if.slave:
//           ExtStrobe, ExtData1..4, ExtAck, INportRead, Address,
//           InpExtWorld1..4, DataReady, Overrun)
//   Option : INPORT_CAPTURE_OVERWRITE_EN - overwrite full channels and flag
//            Overrun instead of back-pressuring the device.
// Revision    : 1.0 - initial release
// ============================================================================
module in_port_capture
    import in_port_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         Reset,
    in_port_capture_if.slave  bus
);

    logic [DATA_W-1:0] w_ext_data [NUM_CH];
    logic [DATA_W-1:0] w_hold     [NUM_CH];
    logic [NUM_CH-1:0] w_ack;
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_overrun;

    assign w_ext_data[0] = bus.ExtData1;
    assign w_ext_data[1] = bus.ExtData2;
    assign w_ext_data[2] = bus.ExtData3;
    assign w_ext_data[3] = bus.ExtData4;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        in_port_chan #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES),
            .ADDR        (ch_addr(i))
        ) u_chan (
            .clk          (clk),
            .rst          (Reset),
            .i_ext_strobe (bus.ExtStrobe[i]),
            .i_ext_data   (w_ext_data[i]),
            .i_rd_en      (bus.INportRead),
            .i_rd_addr    (bus.Address),
            .o_ext_ack    (w_ack[i]),
            .o_data       (w_hold[i]),
            .o_ready      (w_ready[i]),
            .o_overrun    (w_overrun[i])
        );
    end

    assign bus.ExtAck       = w_ack;
    assign bus.DataReady    = w_ready;
    assign bus.Overrun      = w_overrun;
    assign bus.InpExtWorld1 = w_hold[0];
    assign bus.InpExtWorld2 = w_hold[1];
    assign bus.InpExtWorld3 = w_hold[2];
    assign bus.InpExtWorld4 = w_hold[3];

endmodule
`default_nettype wire

// File: tb/tb_in_port_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_port_capture
// Description : Directed self-checking bench for in_port_capture with
//               hand-computed expected values (SYNC_STAGES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_in_port_capture;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    in_port_capture_if #(.DATA_W(8)) bus ();

    in_port_capture #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] addr);
        bus.INportRead = 1'b1;
        bus.Address    = addr;
        tick(1);
        bus.INportRead = 1'b0;
        bus.Address    = 8'h00;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst            = 1'b0;
        bus.ExtStrobe  = 4'h0;
        bus.ExtData1   = 8'h00;
        bus.ExtData2   = 8'h00;
        bus.ExtData3   = 8'h00;
        bus.ExtData4   = 8'h00;
        bus.INportRead = 1'b0;
        bus.Address    = 8'h00;

        // Reset asserted before any clock edge: outputs must clear at once.
        #2 rst = 1'b1;
        #1;
        chk("rst_ack",   32'(bus.ExtAck),       32'h0);
        chk("rst_rdy",   32'(bus.DataReady),    32'h0);
        chk("rst_ovr",   32'(bus.Overrun),      32'h0);
        chk("rst_iw1",   32'(bus.InpExtWorld1), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Channel 0 basic transfer.
        bus.ExtData1  = 8'hA5;
        bus.ExtStrobe = 4'b0001;
        tick(2);
        chk("ch0_ack_early", 32'(bus.ExtAck),       32'h0);
        tick(1);
        chk("ch0_ack",       32'(bus.ExtAck),       32'h1);
        chk("ch0_iw1",       32'(bus.InpExtWorld1), 32'hA5);
        chk("ch0_rdy",       32'(bus.DataReady),    32'h1);
        bus.ExtStrobe = 4'b0000;
        tick(2);
        chk("ch0_ack_hold",  32'(bus.ExtAck),       32'h1);
        tick(1);
        chk("ch0_ack_rel",   32'(bus.ExtAck),       32'h0);
        chk("ch0_rdy_hold",  32'(bus.DataReady),    32'h1);

        // Channel 2 capture then read clear.
        bus.ExtData3  = 8'h3C;
        bus.ExtStrobe = 4'b0100;
        tick(3);
        chk("ch2_ack",       32'(bus.ExtAck),       32'h4);
        bus.ExtStrobe = 4'b0000;
        tick(3);
        chk("ch2_rdy",       32'(bus.DataReady),    32'h5);
        rd(8'h02);
        chk("ch2_rd_clr",    32'(bus.DataReady),    32'h1);
        chk("ch2_iw3_hold",  32'(bus.InpExtWorld3), 32'h3C);
        rd(8'h07);
        chk("rd_addr7_rdy",  32'(bus.DataReady),    32'h1);
        chk("rd_addr7_iw3",  32'(bus.InpExtWorld3), 32'h3C);

        // Channel 1 first byte.
        bus.ExtData2  = 8'h55;
        bus.ExtStrobe = 4'b0010;
        tick(3);
        chk("ch1_iw2",       32'(bus.InpExtWorld2), 32'h55);
        bus.ExtStrobe = 4'b0000;
        tick(3);
        chk("ch1_ack_rel",   32'(bus.ExtAck),       32'h0);
        chk("ch1_rdy",       32'(bus.DataReady),    32'h3);

`ifndef INPORT_CAPTURE_OVERWRITE_EN
        // Back-pressure on full channel 1, released by a read.
        bus.ExtData2  = 8'h77;
        bus.ExtStrobe = 4'b0010;
        tick(5);
        chk("bp_ack_stall",  32'(bus.ExtAck),       32'h0);
        chk("bp_iw2_hold",   32'(bus.InpExtWorld2), 32'h55);
        rd(8'h01);
        chk("bp_rd_clr",     32'(bus.DataReady),    32'h1);
        chk("bp_ack_rd",     32'(bus.ExtAck),       32'h0);
        tick(1);
        chk("bp_ack_cap",    32'(bus.ExtAck),       32'h2);
        chk("bp_iw2_cap",    32'(bus.InpExtWorld2), 32'h77);
        chk("bp_rdy_cap",    32'(bus.DataReady),    32'h3);
        chk("bp_ovr_zero",   32'(bus.Overrun),      32'h0);
        bus.ExtStrobe = 4'b0000;
        tick(3);
        chk("bp_ack_rel",    32'(bus.ExtAck),       32'h0);
`else
        // Overwrite on full channel 3.
        bus.ExtData4  = 8'h11;
        bus.ExtStrobe = 4'b1000;
        tick(3);
        bus.ExtStrobe = 4'b0000;
        tick(3);
        chk("ow_rdy_first",  32'(bus.DataReady),    32'hB);
        bus.ExtData4  = 8'h22;
        bus.ExtStrobe = 4'b1000;
        tick(3);
        chk("ow_ack",        32'(bus.ExtAck),       32'h8);
        chk("ow_iw4",        32'(bus.InpExtWorld4), 32'h22);
        chk("ow_ovr",        32'(bus.Overrun),      32'h8);
        bus.ExtStrobe = 4'b0000;
        tick(3);
        rd(8'h03);
        chk("ow_rd_rdy",     32'(bus.DataReady),    32'h3);
        chk("ow_rd_ovr",     32'(bus.Overrun),      32'h0);
        chk("ow_iw4_hold",   32'(bus.InpExtWorld4), 32'h22);
`endif

        rd(8'h00);
        rd(8'h01);
        chk("all_clear",     32'(bus.DataReady),    32'h0);

        // All four channels capture together.
        bus.ExtData1  = 8'h81;
        bus.ExtData2  = 8'h92;
        bus.ExtData3  = 8'hA3;
        bus.ExtData4  = 8'hB4;
        bus.ExtStrobe = 4'hF;
        tick(2);
        chk("cc_ack_early",  32'(bus.ExtAck),       32'h0);
        tick(1);
        chk("cc_ack",        32'(bus.ExtAck),       32'hF);
        chk("cc_rdy",        32'(bus.DataReady),    32'hF);
        chk("cc_iw1",        32'(bus.InpExtWorld1), 32'h81);
        chk("cc_iw2",        32'(bus.InpExtWorld2), 32'h92);
        chk("cc_iw3",        32'(bus.InpExtWorld3), 32'hA3);
        chk("cc_iw4",        32'(bus.InpExtWorld4), 32'hB4);

        // Mid-cycle reset during the handshake, strobes still high.
        #2 rst = 1'b1;
        #1;
        chk("mr_ack",        32'(bus.ExtAck),       32'h0);
        chk("mr_rdy",        32'(bus.DataReady),    32'h0);
        chk("mr_iw4",        32'(bus.InpExtWorld4), 32'h0);
        #2 rst = 1'b0;
        tick(2);
        chk("rc_ack_early",  32'(bus.ExtAck),       32'h0);
        tick(1);
        chk("rc_ack",        32'(bus.ExtAck),       32'hF);
        chk("rc_rdy",        32'(bus.DataReady),    32'hF);
        chk("rc_iw2",        32'(bus.InpExtWorld2), 32'h92);
        bus.ExtStrobe = 4'h0;
        tick(3);
        chk("rc_ack_rel",    32'(bus.ExtAck),       32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/in_port_capture.md
Name: in_port_capture

Overview:
- Upstream front-end for INport. It captures bytes from four external devices using a four-phase strobe/ack handshake.
- Holds each byte in a stable register that drives INport's InpExtWorld1..4 inputs.
- Flags data-ready per channel to the control unit.
- Clears a channel's ready flag when the CPU reads that channel through INport.

Parameters:
- DATA_W, 8, width of each channel's data path.
- SYNC_STAGES, 2, number of flops in each strobe synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- ExtStrobe  input  4  per-channel device strobe, asynchronous to clk; bit n belongs to channel n
- ExtData1..ExtData4  input  DATA_W each  device data; must be stable while the matching strobe is high
- ExtAck  output  4  per-channel acknowledge to the device
- INportRead  input  1  same signal that drives INport's read enable
- Address  input  8  same address bus that drives INport
- InpExtWorld1..InpExtWorld4  output  DATA_W each  holding registers; connect to INport
- DataReady  output  4  per-channel "unread byte held"
- Overrun  output  4  per-channel sticky lost-byte flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on Reset.
- Reset values: InpExtWorld* = 0, ExtAck = 0, DataReady = 0, Overrun = 0, all synchronizer flops = 0, every channel FSM = IDLE.
- Strobe synchronization: ExtStrobe[n] passes through SYNC_STAGES flops to give strb_s[n]. Only strb_s is used internally.
- Each channel runs an independent FSM with two states, IDLE and ACK.
- IDLE:
  - If strb_s = 1 and DataReady = 0: register ExtDataN into InpExtWorldN, set DataReady = 1, set ExtAck = 1, go to ACK.
  - If strb_s = 1 and DataReady = 1: stay in IDLE and keep ExtAck at 0, so the device stalls (back-pressure).
- ACK:
  - Hold ExtAck = 1 until strb_s = 0.
  - On the edge where strb_s = 0 is seen, ExtAck goes to 0 and the FSM returns to IDLE.
  - The data register does not change while in ACK.
- Latency: with the strobe rising and data set up before clk edge k, data is captured and ExtAck rises at edge k + SYNC_STAGES.
  - With SYNC_STAGES = 2, ExtAck is visible 2 cycles after the strobe is first sampled.
  - Release has the same SYNC_STAGES delay.
- Read clear: when INportRead = 1 and Address = channel n (8'h00..8'h03), DataReady[n] clears on that edge.
  - INport samples InpExtWorldN on the same edge, so it receives the held byte.
  - Addresses 8'h04..8'hFF clear nothing.
- Simultaneous read and new strobe on a full channel:
  - The read wins: DataReady clears on this edge.
  - Capture happens on the following edge, because capture in IDLE requires DataReady = 0 as of the current cycle.
- InpExtWorldN changes only on a capture edge. Between captures it holds its value indefinitely, including after a read.
- Reset in mid-handshake: the FSM returns to IDLE and ExtAck drops immediately.
  - If the strobe is still high after reset is released, it is treated as a new transfer and captured again.
- Channels never interact. All four may capture on the same edge.

Optional Feature:
- Macro: INPORT_CAPTURE_OVERWRITE_EN.
- Defined:
  - In IDLE with strb_s = 1 and DataReady = 1, capture anyway: overwrite InpExtWorldN, set Overrun[n] = 1, go to ACK. No back-pressure.
  - Overrun[n] clears on the same read-clear condition as DataReady[n].
  - If an overwrite and a read happen on the same edge, the overwrite wins: Overrun = 1 and DataReady stays 1.
- Undefined: back-pressure behaviour as specified in Behaviour. Overrun is tied to 0.

Decomposition:
- Package in_port_pkg:
  - typedef enum for the channel FSM: IDLE, ACK.
  - localparams CH0_ADDR..CH3_ADDR = 8'h00..8'h03, which must match INport's decode.
  - localparam NUM_CH = 4.
- Sub-module in_port_chan: one channel containing the synchronizer, FSM, data register, DataReady and Overrun. It is instantiated four times by in_port_capture with ADDR as a parameter.

Test Plan:
- Reset: assert Reset mid-cycle -> all outputs read 0 asynchronously; the FSM is in IDLE after release.
- Basic transfer, ch0: ExtData1 = 8'hA5, raise ExtStrobe[0] -> ExtAck[0] = 1, InpExtWorld1 = A5 and DataReady[0] = 1 after 2 edges. Drop the strobe -> ExtAck[0] = 0 after 2 edges.
- Read clear, ch2: held 8'h3C; pulse INportRead with Address = 8'h02 -> DataReady[2] = 0 on that edge, InpExtWorld3 still 3C. Repeat with Address = 8'h07 -> no flag changes.
- Back-pressure, ch1 (macro off): second strobe with 8'h77 while DataReady[1] = 1 -> ExtAck[1] stays 0 and InpExtWorld2 unchanged. Read Address = 8'h01 -> 77 captured and ExtAck[1] = 1 one edge later.
- Overwrite, ch3 (macro on): full with 8'h11, strobe with 8'h22 -> InpExtWorld4 = 22, Overrun[3] = 1. Read Address = 8'h03 -> both flags clear.
- Concurrency: all four strobes rise together with distinct data -> all four capture on the same edge. Reset asserted while ExtAck = 4'hF -> ExtAck = 0 at once, and recapture after release while the strobes are still high.
